cartoon_avm_bridge: RTL and testbench
=====================================

# cartoon_avm_bridge

Single-outstanding Avalon-MM master bridge placed directly downstream of the cartoonifier core's master port. Accepts the core's level-held read/write requests, drives them onto the Avalon bus honouring `avm_waitrequest`, waits for the matching read data or write response, and returns a one-cycle completion pulse to the core. Provides base-address offsetting, request priority resolution and optional hang protection.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte offset added to every core address.
- `TIMEOUT_CYCLES`, 1024: response-wait limit in cycles, range 2..65535; used only with the timeout feature.
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `core_read_enable` in 1: read request; held high until `core_readdatavalid`.
- `core_write_enable` in 1: write request; held high until `core_writeresponsevalid`.
- `core_address` in 32: request byte address.
- `core_writedata` in 32: write data.
- `core_readdata` out 32: read result; valid with `core_readdatavalid`.
- `core_readdatavalid` out 1: one-cycle read completion.
- `core_writeresponsevalid` out 1: one-cycle write completion.
- `avm_address` out 32: `BASE_ADDR + core_address`, modulo 2^32.
- `avm_read` out 1, `avm_write` out 1: Avalon commands.
- `avm_writedata` out 32; `avm_byteenable` out 4: constant 4'hF.
- `avm_waitrequest` in 1; `avm_readdata` in 32; `avm_readdatavalid` in 1; `avm_writeresponsevalid` in 1.
- `err` out 1: sticky error (timeout, simultaneous request, stray response); cleared only by reset.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: on `core_write_enable` -> latch address+BASE_ADDR and data, go WR_REQ; else on `core_read_enable` -> latch address, go RD_REQ. Both high: write wins, `err` set.
- RD_REQ/WR_REQ: `avm_read`/`avm_write` high with latched address/data. Held, unchanged, while `avm_waitrequest`=1. On `avm_waitrequest`=0 go RD_WAIT/WR_WAIT.
- RD_WAIT: on `avm_readdatavalid` capture `avm_readdata`, pulse `core_readdatavalid`, go DONE.
- WR_WAIT: on `avm_writeresponsevalid` pulse `core_writeresponsevalid`, go DONE.
- Response arriving in the acceptance cycle (REQ state with `avm_waitrequest`=0): completed immediately, bypassing WAIT.
- DONE: one-cycle turnaround so the core can drop its enable; always -> IDLE. No request is accepted in DONE.
- Responses in IDLE/DONE or of wrong type (e.g. `avm_writeresponsevalid` in RD_WAIT): ignored, `err` set.
- `core_readdata` holds its last captured value until the next read completes.

## Timing
- Reset values: all outputs 0; state IDLE; latches 0; `err` 0.
- Request seen in IDLE at cycle N -> `avm_read`/`avm_write` high from N+1 (registered outputs).
- Zero-wait bus with response L cycles after acceptance: core completion pulse registered one cycle after the bus response; earliest re-accept is 2 cycles after the pulse.
- Completion pulses are exactly one cycle; never both in the same cycle.
- Reset mid-transaction aborts immediately; a late bus response after reset is a stray (`err` set).

## Configuration
- `CARTOON_AVM_TIMEOUT_EN` defined: a 16-bit counter runs in RD_WAIT/WR_WAIT; reaching `TIMEOUT_CYCLES` without a response forces completion (read returns 32'h0), sets `err`, goes DONE. Wait in REQ states is not timed.
- Undefined: no counter; the bridge waits indefinitely for a response.

## Test plan
- Read, BASE_ADDR=32'h1000, core_address=32'h40, waitrequest low, readdata 32'hA5A5_0001 two cycles later -> `avm_address`=32'h1040, `core_readdata`=32'hA5A5_0001 with a single pulse, `err`=0.
- Write 32'h00FF_8800 to 32'h8, waitrequest high 3 cycles -> `avm_write`/address/data stable for 4 cycles, one `core_writeresponsevalid` pulse after the response.
- Both enables high in IDLE -> write issued first, `err`=1; read serviced after DONE.
- Address wrap: BASE_ADDR=32'hFFFF_FFF0, core_address=32'h20 -> `avm_address`=32'h10.
- With `CARTOON_AVM_TIMEOUT_EN`, TIMEOUT_CYCLES=8, read never answered -> `core_readdatavalid` with data 0 after 8 wait cycles, `err`=1; a later stray response is ignored.
- Assert `n_rst` in WR_WAIT -> outputs 0 asynchronously; next request proceeds normally.

Source files
------------

// File: rtl/cartoon_avm_bridge.sv
// Single-outstanding Avalon-MM master bridge between the cartoonifier core and the bus.
// Optional response-wait hang protection is enabled by defining CARTOON_AVM_TIMEOUT_EN.
module cartoon_avm_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    input  logic [31:0] core_address,
    input  logic [31:0] core_writedata,
    output logic [31:0] core_readdata,
    output logic        core_readdatavalid,
    output logic        core_writeresponsevalid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_writeresponsevalid,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        rd_done_s;
    logic        wr_done_s;
    logic [31:0] rdata_s;
    logic        err_set_s;
    logic        timeout_hit_s;

`ifdef CARTOON_AVM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST_C = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0] wait_cnt_r;

    // Response-wait counter, cleared whenever the bridge is not waiting on the bus
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r == RD_WAIT) || (state_r == WR_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= 16'd0;
        end
    end

    assign timeout_hit_s = ((state_r == RD_WAIT) || (state_r == WR_WAIT)) &&
                           (wait_cnt_r == TIMEOUT_LAST_C);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state, completion and error detection
    always_comb begin
        next_state_s = state_r;
        rd_done_s    = 1'b0;
        wr_done_s    = 1'b0;
        rdata_s      = avm_readdata;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (core_write_enable) begin
                    next_state_s = WR_REQ;
                    err_set_s    = core_read_enable;
                end else if (core_read_enable) begin
                    next_state_s = RD_REQ;
                end else begin
                    next_state_s = IDLE;
                end
                err_set_s = err_set_s | avm_readdatavalid | avm_writeresponsevalid;
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        rd_done_s    = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RD_WAIT;
                    end
                end else begin
                    next_state_s = RD_REQ;
                    err_set_s    = avm_readdatavalid;
                end
                err_set_s = err_set_s | avm_writeresponsevalid;
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rd_done_s    = 1'b1;
                    next_state_s = DONE;
                end else if (timeout_hit_s) begin
                    rd_done_s    = 1'b1;
                    rdata_s      = 32'h0000_0000;
                    err_set_s    = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RD_WAIT;
                end
                err_set_s = err_set_s | avm_writeresponsevalid;
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_writeresponsevalid) begin
                        wr_done_s    = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = WR_WAIT;
                    end
                end else begin
                    next_state_s = WR_REQ;
                    err_set_s    = avm_writeresponsevalid;
                end
                err_set_s = err_set_s | avm_readdatavalid;
            end
            WR_WAIT: begin
                if (avm_writeresponsevalid) begin
                    wr_done_s    = 1'b1;
                    next_state_s = DONE;
                end else if (timeout_hit_s) begin
                    wr_done_s    = 1'b1;
                    err_set_s    = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = WR_WAIT;
                end
                err_set_s = err_set_s | avm_readdatavalid;
            end
            DONE: begin
                next_state_s = IDLE;
                err_set_s    = avm_readdatavalid | avm_writeresponsevalid;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and registered bus/core outputs; commands follow the next state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r                 <= IDLE;
            avm_read                <= 1'b0;
            avm_write               <= 1'b0;
            avm_address             <= 32'h0000_0000;
            avm_writedata           <= 32'h0000_0000;
            avm_byteenable          <= 4'h0;
            core_readdata           <= 32'h0000_0000;
            core_readdatavalid      <= 1'b0;
            core_writeresponsevalid <= 1'b0;
            err                     <= 1'b0;
        end else begin
            state_r                 <= next_state_s;
            avm_read                <= (next_state_s == RD_REQ);
            avm_write               <= (next_state_s == WR_REQ);
            avm_byteenable          <= 4'hF;
            core_readdatavalid      <= rd_done_s;
            core_writeresponsevalid <= wr_done_s;
            if ((state_r == IDLE) && (next_state_s != IDLE)) begin
                avm_address <= BASE_ADDR + core_address;
            end
            if ((state_r == IDLE) && (next_state_s == WR_REQ)) begin
                avm_writedata <= core_writedata;
            end
            if (rd_done_s) begin
                core_readdata <= rdata_s;
            end
            if (err_set_s) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cartoon_avm_bridge.sv
// Scoreboard bench for cartoon_avm_bridge: directed transactions, monitor checks bus commands and completions.
module tb_cartoon_avm_bridge;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        core_read_enable = 1'b0;
    logic        core_write_enable = 1'b0;
    logic [31:0] core_address = 32'h0;
    logic [31:0] core_writedata = 32'h0;
    logic [31:0] core_readdata;
    logic        core_readdatavalid;
    logic        core_writeresponsevalid;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_writeresponsevalid = 1'b0;
    logic        err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t cmd_q[$];
    txn_t resp_q[$];
    bit   prev_pulse = 1'b0;

    cartoon_avm_bridge #(
        .BASE_ADDR     (32'h0000_1000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .core_read_enable       (core_read_enable),
        .core_write_enable      (core_write_enable),
        .core_address           (core_address),
        .core_writedata         (core_writedata),
        .core_readdata          (core_readdata),
        .core_readdatavalid     (core_readdatavalid),
        .core_writeresponsevalid(core_writeresponsevalid),
        .avm_address            (avm_address),
        .avm_read               (avm_read),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_byteenable         (avm_byteenable),
        .avm_waitrequest        (avm_waitrequest),
        .avm_readdata           (avm_readdata),
        .avm_readdatavalid      (avm_readdatavalid),
        .avm_writeresponsevalid (avm_writeresponsevalid),
        .err                    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented command and completion pulse against the queues
    always @(negedge clk) begin
        if (n_rst) begin
            if (avm_read || avm_write) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {avm_write, avm_read, avm_address}, 128'h0);
                end else begin
                    chk("cmd", {avm_write, avm_read, avm_address,
                                (cmd_q[0].we ? avm_writedata : 32'h0), avm_byteenable},
                        {cmd_q[0].we, ~cmd_q[0].we, cmd_q[0].addr,
                         (cmd_q[0].we ? cmd_q[0].data : 32'h0), 4'hF});
                    if (!avm_waitrequest) void'(cmd_q.pop_front());
                end
            end
            if (core_readdatavalid || core_writeresponsevalid) begin
                chk("pulse_excl", {core_readdatavalid, core_writeresponsevalid, prev_pulse},
                    {~core_writeresponsevalid, ~core_readdatavalid, 1'b0});
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", {core_readdatavalid, core_writeresponsevalid}, 128'h0);
                end else begin
                    chk("resp", {core_writeresponsevalid, core_readdatavalid,
                                 (resp_q[0].we ? 32'h0 : core_readdata)},
                        {resp_q[0].we, ~resp_q[0].we, (resp_q[0].we ? 32'h0 : resp_q[0].data)});
                    void'(resp_q.pop_front());
                end
            end
            prev_pulse = core_readdatavalid | core_writeresponsevalid;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] data);
        core_address   = addr;
        core_writedata = data;
        if (we) core_write_enable = 1'b1;
        else    core_read_enable  = 1'b1;
    endtask

    // Bus model: accept after wait_n stalls, respond lat cycles after acceptance (lat<0: never)
    task automatic service(input bit we, input int wait_n, input int lat,
                           input logic [31:0] rdata, output int waited);
        int n = 0;
        avm_waitrequest = (wait_n > 0);
        while (!(avm_read || avm_write) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("cmd_timeout", 128'(n), 128'h0);
        for (int i = 0; i < wait_n; i++) tick();
        avm_waitrequest = 1'b0;
        avm_readdata    = rdata;
        if (lat == 0) begin
            avm_readdatavalid      = ~we;
            avm_writeresponsevalid = we;
        end
        tick();
        avm_readdatavalid      = 1'b0;
        avm_writeresponsevalid = 1'b0;
        if (lat > 0) begin
            for (int i = 0; i < lat - 1; i++) tick();
            avm_readdatavalid      = ~we;
            avm_writeresponsevalid = we;
            tick();
            avm_readdatavalid      = 1'b0;
            avm_writeresponsevalid = 1'b0;
        end
        waited = 0;
        while (!(core_readdatavalid || core_writeresponsevalid) && waited < 40) begin
            tick();
            waited++;
        end
        if (waited >= 40) chk("pulse_timeout", 128'(waited), 128'h0);
        if (we) core_write_enable = 1'b0;
        else    core_read_enable  = 1'b0;
    endtask

    task automatic push(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata);
        cmd_q.push_back('{we, addr, wdata});
        resp_q.push_back('{we, 32'h0, rdata});
    endtask

    initial begin
        int w;
        #1;
        chk("reset_outputs", {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
                              core_readdata, core_readdatavalid, core_writeresponsevalid, err}, 128'h0);
        tick();
        n_rst = 1'b1;
        tick();

        // Read with base offset, response two cycles after acceptance
        push(1'b0, 32'h0000_1040, 32'h0, 32'hA5A5_0001);
        issue(1'b0, 32'h0000_0040, 32'h0);
        service(1'b0, 0, 2, 32'hA5A5_0001, w);
        tick();
        chk("err_after_read", err, 1'b0);

        // Write stalled by waitrequest for 3 cycles
        push(1'b1, 32'h0000_1008, 32'h00FF_8800, 32'h0);
        issue(1'b1, 32'h0000_0008, 32'h00FF_8800);
        service(1'b1, 3, 1, 32'h0, w);
        tick();
        chk("err_after_write", err, 1'b0);
        chk("readdata_hold", core_readdata, 32'hA5A5_0001);

        // Address wrap, response in the acceptance cycle
        push(1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D);
        issue(1'b0, 32'hFFFF_F010, 32'h0);
        service(1'b0, 1, 0, 32'h0BAD_F00D, w);
        tick();

        push(1'b1, 32'h0000_1004, 32'h1357_9BDF, 32'h0);
        issue(1'b1, 32'h0000_0004, 32'h1357_9BDF);
        service(1'b1, 0, 0, 32'h0, w);
        tick();
        chk("err_clean", err, 1'b0);

        // Stray write response in IDLE
        avm_writeresponsevalid = 1'b1;
        tick();
        avm_writeresponsevalid = 1'b0;
        tick();
        chk("err_stray", err, 1'b1);

        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        chk("err_cleared", err, 1'b0);

        // Both enables: write first with err, then read after DONE
        push(1'b1, 32'h0000_1010, 32'hCAFE_0002, 32'h0);
        push(1'b0, 32'h0000_1010, 32'h0, 32'h7777_0003);
        core_read_enable = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hCAFE_0002);
        service(1'b1, 0, 1, 32'h0, w);
        tick();
        chk("err_both", err, 1'b1);
        service(1'b0, 2, 1, 32'h7777_0003, w);
        tick();

        // Reset in WR_WAIT, then a late response and a fresh read
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        cmd_q.push_back('{1'b1, 32'h0000_1020, 32'h1234_5678});
        issue(1'b1, 32'h0000_0020, 32'h1234_5678);
        tick();
        avm_waitrequest = 1'b0;
        tick();
        n_rst = 1'b0;
        #1;
        chk("async_reset", {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
                            core_readdata, core_readdatavalid, core_writeresponsevalid, err}, 128'h0);
        core_write_enable = 1'b0;
        tick();
        n_rst = 1'b1;
        avm_writeresponsevalid = 1'b1;
        tick();
        avm_writeresponsevalid = 1'b0;
        tick();
        chk("err_late_resp", err, 1'b1);
        push(1'b0, 32'h0000_1080, 32'h0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0080, 32'h0);
        service(1'b0, 1, 1, 32'hDEAD_BEEF, w);
        tick();

`ifdef CARTOON_AVM_TIMEOUT_EN
        // Unanswered read times out after 8 wait cycles with zero data
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        push(1'b0, 32'h0000_1100, 32'h0, 32'h0);
        issue(1'b0, 32'h0000_0100, 32'h0);
        service(1'b0, 0, -1, 32'h5555_5555, w);
        chk("timeout_cycles", 128'(w), 128'd8);
        tick();
        chk("err_timeout", err, 1'b1);
        avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        tick();
        chk("err_after_stray", err, 1'b1);
`endif

        tick();
        tick();
        chk("cmd_q_empty", 128'(cmd_q.size()), 128'h0);
        chk("resp_q_empty", 128'(resp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
